// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Fetch/loader arbiter for a single-port sync-read instruction RAM,
//            with loader-burst starvation guard. Optional: IMEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module imem_arbiter #(
  parameter int MEM_AW       = 8,
  parameter int MAX_LD_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [`ADDR_LEN-1:0]  fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [`INSTR_LEN-1:0] fetch_inst,
  output logic                  cpu_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [`ADDR_LEN-1:0]  ld_addr,
  input  logic [`INSTR_LEN-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [`INSTR_LEN-1:0] ld_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [`INSTR_LEN-1:0] mem_wdata,
`ifdef IMEM_ARB_STATS_EN
  output logic [15:0]           stall_cnt,
  output logic [15:0]           ld_wr_cnt,
`endif
  input  logic [`INSTR_LEN-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    LD_PRI      = 1'b0,
    FETCH_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD    = 2'd2
  } owner_t;

  localparam logic [3:0] c_BURST_LAST = 4'(MAX_LD_BURST - 1);

  arb_state_t r_state, w_state_nxt;
  owner_t     r_owner, w_owner_nxt;
  logic [3:0] r_burst_cnt, w_burst_nxt;
  logic [`INSTR_LEN-1:0] r_fetch_hold, r_ld_hold;

  logic w_fetch_gnt, w_ld_gnt;
  logic [MEM_AW-1:0] w_fetch_word, w_ld_word;
  logic w_unused_addr;

  assign w_fetch_word  = fetch_addr[MEM_AW+1:2];
  assign w_ld_word     = ld_addr[MEM_AW+1:2];
  assign w_unused_addr = ^{fetch_addr, ld_addr};

  // Loader wins unless fetch is pending and the burst guard has tripped.
  assign w_ld_gnt    = ld_req & (~fetch_req | (r_state == LD_PRI));
  assign w_fetch_gnt = fetch_req & ~w_ld_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    if (!fetch_req) begin
      w_state_nxt = LD_PRI;
      w_burst_nxt = 4'd0;
    end else begin
      case (r_state)
        LD_PRI: begin
          if (w_ld_gnt) begin
            w_burst_nxt = r_burst_cnt + 4'd1;
            if (r_burst_cnt == c_BURST_LAST) w_state_nxt = FETCH_FORCE;
          end else begin
            w_burst_nxt = 4'd0;
          end
        end
        FETCH_FORCE: begin
          w_state_nxt = LD_PRI;
          w_burst_nxt = 4'd0;
        end
        default: begin
          w_state_nxt = LD_PRI;
          w_burst_nxt = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_fetch_gnt)          w_owner_nxt = OWN_FETCH;
    else if (w_ld_gnt && !ld_we) w_owner_nxt = OWN_LD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LD_PRI;
      r_burst_cnt  <= 4'd0;
      r_owner      <= OWN_NONE;
      r_fetch_hold <= '0;
      r_ld_hold    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_owner     <= w_owner_nxt;
      if (r_owner == OWN_FETCH) r_fetch_hold <= mem_rdata;
      if (r_owner == OWN_LD)    r_ld_hold    <= mem_rdata;
    end
  end

  assign fetch_gnt = w_fetch_gnt;
  assign ld_gnt    = w_ld_gnt;
  assign cpu_stall = fetch_req & ~w_fetch_gnt;

  assign mem_en    = w_fetch_gnt | w_ld_gnt;
  assign mem_we    = w_ld_gnt & ld_we;
  assign mem_addr  = w_ld_gnt ? w_ld_word : (w_fetch_gnt ? w_fetch_word : '0);
  assign mem_wdata = w_ld_gnt ? ld_wdata : '0;

  // Read data is passed straight from the RAM in the return cycle; the hold
  // registers keep the last value afterwards. Reset masks any in-flight return.
  assign fetch_rvalid = (r_owner == OWN_FETCH) & ~rst;
  assign ld_rvalid    = (r_owner == OWN_LD) & ~rst;
  assign fetch_inst   = rst ? '0 : ((r_owner == OWN_FETCH) ? mem_rdata : r_fetch_hold);
  assign ld_rdata     = rst ? '0 : ((r_owner == OWN_LD) ? mem_rdata : r_ld_hold);

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt, r_ld_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_ld_wr_cnt <= 16'd0;
    end else begin
      if (cpu_stall && r_stall_cnt != 16'hFFFF)        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_ld_gnt && ld_we && r_ld_wr_cnt != 16'hFFFF) r_ld_wr_cnt <= r_ld_wr_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign ld_wr_cnt = r_ld_wr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Brief    : Directed scoreboard bench for imem_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] fetch_addr = '0, ld_addr = '0, ld_wdata = '0;
  logic fetch_gnt, fetch_rvalid, cpu_stall, ld_gnt, ld_rvalid, mem_en, mem_we;
  logic [31:0] fetch_inst, ld_rdata, mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  mem_addr;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stall_cnt, ld_wr_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q_fetch[$];
  logic [31:0] q_ld[$];

  always #5 clk = ~clk;

  imem_arbiter #(.MEM_AW(8), .MAX_LD_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_inst(fetch_inst), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef IMEM_ARB_STATS_EN
    .stall_cnt(stall_cnt), .ld_wr_cnt(ld_wr_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  // RAM: unwritten word i reads as 32'hA000_0000 | i
  logic [31:0] mem [256];
  bit          wrote [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]   <= mem_wdata;
        wrote[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wrote[mem_addr] ? mem[mem_addr] : (32'hA000_0000 | {24'd0, mem_addr});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (fetch_rvalid) begin
      if (q_fetch.size() == 0) begin
        n_checks++;
        $display("FAIL fetch_rvalid: got unexpected pulse, data %h expected none", fetch_inst);
      end else chk("fetch_inst", fetch_inst, q_fetch.pop_front());
    end
    if (ld_rvalid) begin
      if (q_ld.size() == 0) begin
        n_checks++;
        $display("FAIL ld_rvalid: got unexpected pulse, data %h expected none", ld_rdata);
      end else chk("ld_rdata", ld_rdata, q_ld.pop_front());
    end
  end

  task automatic cyc(input string tag, input logic r,
                     input logic fq, input logic [31:0] fa,
                     input logic lq, input logic lw, input logic [31:0] la, input logic [31:0] lwd,
                     input logic ef, input logic el, input logic [7:0] ea,
                     input logic pushr, input logic [31:0] ed);
    @(posedge clk);
    #1;
    rst = r; fetch_req = fq; fetch_addr = fa;
    ld_req = lq; ld_we = lw; ld_addr = la; ld_wdata = lwd;
    #1;
    chk({tag, ".fetch_gnt"}, {31'd0, fetch_gnt}, {31'd0, ef});
    chk({tag, ".ld_gnt"},    {31'd0, ld_gnt},    {31'd0, el});
    chk({tag, ".cpu_stall"}, {31'd0, cpu_stall}, {31'd0, fq & ~ef});
    chk({tag, ".mem_en"},    {31'd0, mem_en},    {31'd0, ef | el});
    if (ef || el) begin
      chk({tag, ".mem_addr"},  {24'd0, mem_addr}, {24'd0, ea});
      chk({tag, ".mem_we"},    {31'd0, mem_we},   {31'd0, el & lw});
      chk({tag, ".mem_wdata"}, mem_wdata,         el ? lwd : 32'd0);
    end
    if (pushr) begin
      if (ef) q_fetch.push_back(ed);
      else    q_ld.push_back(ed);
    end
  endtask

  task automatic idle(input logic r);
    cyc("idle", r, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, ".fetch_rvalid"}, {31'd0, fetch_rvalid}, 32'd0);
    chk({tag, ".ld_rvalid"},    {31'd0, ld_rvalid},    32'd0);
    chk({tag, ".fetch_inst"},   fetch_inst,            32'd0);
    chk({tag, ".ld_rdata"},     ld_rdata,              32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle(1); idle(1);
    chk_regs_zero("rst");
    idle(0);
    chk_regs_zero("post_rst");

    // Fetch-only sequential reads
    cyc("f0", 0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 8'd0, 1, 32'hA000_0000);
    cyc("f1", 0, 1, 32'h4, 0, 0, 0, 0, 1, 0, 8'd1, 1, 32'hA000_0001);
    cyc("f2", 0, 1, 32'h8, 0, 0, 0, 0, 1, 0, 8'd2, 1, 32'hA000_0002);
    idle(0);

    // Loader write then readback; the write must not return data
    cyc("lw", 0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 1, 8'd4, 0, 0);
    cyc("lr", 0, 0, 0, 1, 0, 32'h10, 32'h0, 0, 1, 8'd4, 1, 32'hDEAD_BEEF);
    idle(0);

    // Address wrap and ignored byte-offset bits
    cyc("wrap",  0, 1, 32'h400, 0, 0, 0, 0, 1, 0, 8'd0,   1, 32'hA000_0000);
    cyc("boff",  0, 1, 32'h7,   0, 0, 0, 0, 1, 0, 8'd1,   1, 32'hA000_0001);
    cyc("top",   0, 1, 32'h3FC, 0, 0, 0, 0, 1, 0, 8'd255, 1, 32'hA000_00FF);
    idle(0);

    // Contention: L,L,L,L,F repeating
    for (int i = 0; i < 12; i++) begin
      logic f;
      f = (i % 5 == 4);
      cyc("cont", 0, 1, 32'h30, 1, 0, 32'h20, 0, f, !f, f ? 8'd12 : 8'd8, 1,
          f ? 32'hA000_000C : 32'hA000_0008);
    end
    idle(0);

    // Counter phase from a clean reset
    idle(1);
    cyc("sw1", 0, 1, 32'h30, 1, 1, 32'h40, 32'h1111_0001, 0, 1, 8'd16, 0, 0);
    cyc("sw2", 0, 1, 32'h30, 1, 1, 32'h44, 32'h1111_0002, 0, 1, 8'd17, 0, 0);
    cyc("sw3", 0, 1, 32'h30, 1, 1, 32'h48, 32'h1111_0003, 0, 1, 8'd18, 0, 0);
    cyc("sr4", 0, 1, 32'h30, 1, 0, 32'h40, 0, 0, 1, 8'd16, 1, 32'h1111_0001);
    cyc("sf5", 0, 1, 32'h30, 1, 0, 32'h44, 0, 1, 0, 8'd12, 1, 32'hA000_000C);
    cyc("sr6", 0, 1, 32'h30, 1, 0, 32'h44, 0, 0, 1, 8'd17, 1, 32'h1111_0002);
    idle(0);
`ifdef IMEM_ARB_STATS_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd5);
    chk("ld_wr_cnt", {16'd0, ld_wr_cnt}, 32'd3);
    force dut.r_stall_cnt = 16'hFFFF;
    #1;
    release dut.r_stall_cnt;
    cyc("sat", 0, 1, 32'h30, 1, 0, 32'h40, 0, 0, 1, 8'd16, 1, 32'h1111_0001);
    idle(0);
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("ld_wr_hold", {16'd0, ld_wr_cnt}, 32'd3);
`endif

    // Reset right after a fetch grant drops the return
    cyc("rf", 0, 1, 32'h8, 0, 0, 0, 0, 1, 0, 8'd2, 0, 0);
    idle(1);
    chk_regs_zero("midrst");
    idle(0);

    // Reach FETCH_FORCE, then reset: grant still combinational, state back to LD_PRI
    for (int i = 0; i < 4; i++)
      cyc("fw", 0, 1, 32'h30, 1, 1, 32'h80 + 32'(4 * i), 32'h2222_0000 + 32'(i),
          0, 1, 8'd32 + 8'(i), 0, 0);
    cyc("frst",  1, 1, 32'h30, 1, 1, 32'h90, 32'h3333_3333, 1, 0, 8'd12, 0, 0);
    cyc("fpost", 0, 1, 32'h30, 1, 0, 32'h80, 0, 0, 1, 8'd32, 1, 32'h2222_0000);
    idle(0);
    idle(0);
    idle(0);

    chk("q_fetch_empty", 32'(q_fetch.size()), 32'd0);
    chk("q_ld_empty",    32'(q_ld.size()),    32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory (256 words x `INSTR_LEN) between two requesters: the CPU fetch stage (read-only) and the program loader (read/write, used for boot-time load and readback).
- Sits between the fetch/PC logic, the loader, and the instruction RAM.
- Arbitrates each cycle and tracks the one-cycle read latency per requester.
- Starvation guard: a streaming loader cannot lock out fetch indefinitely.

Parameters:
- MEM_AW, 8, word-address width of the memory (depth 2^MEM_AW words).
- MAX_LD_BURST, 4, maximum consecutive loader grants while fetch is pending; range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- fetch_req  input  1  fetch read request.
- fetch_addr  input  `ADDR_LEN  byte address; word index = fetch_addr[MEM_AW+1:2].
- fetch_gnt  output  1  fetch granted this cycle (combinational).
- fetch_rvalid  output  1  fetch_inst valid (registered, one cycle after grant).
- fetch_inst  output  `INSTR_LEN  instruction read data.
- cpu_stall  output  1  fetch_req high and fetch_gnt low this cycle.
- ld_req  input  1  loader request.
- ld_we  input  1  1 = write, 0 = read.
- ld_addr  input  `ADDR_LEN  byte address, word index as above.
- ld_wdata  input  `INSTR_LEN  write data.
- ld_gnt  output  1  loader granted this cycle (combinational).
- ld_rvalid  output  1  ld_rdata valid (registered, one cycle after a granted read).
- ld_rdata  output  `INSTR_LEN  loader read data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  MEM_AW  memory word index.
- mem_wdata  output  `INSTR_LEN  memory write data.
- mem_rdata  input  `INSTR_LEN  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- One access per cycle. fetch_gnt and ld_gnt are mutually exclusive.
- Policy state, registered:
  - burst_cnt[3:0] counts consecutive loader grants made while fetch_req was high.
  - FSM states:
    - LD_PRI: loader wins if ld_req.
    - FETCH_FORCE: fetch wins if fetch_req.
  - LD_PRI -> FETCH_FORCE when a loader grant occurs with fetch_req high and burst_cnt == MAX_LD_BURST-1.
  - FETCH_FORCE -> LD_PRI after one fetch grant, or immediately if fetch_req is low. burst_cnt clears on that transition.
  - burst_cnt clears in any cycle where fetch_req is low.
- Grant with only one requester: that requester is granted regardless of state.
- Grant with neither requester: mem_en=0.
- Memory drive, same cycle as grant:
  - mem_en=1, mem_addr = granted word index.
  - mem_we = ld_we for a loader grant, 0 for a fetch grant.
  - mem_wdata = ld_wdata for a loader grant, 0 otherwise.
- Read return:
  - Register rd_owner (NONE/FETCH/LD) at grant.
  - Next cycle, fetch_rvalid or ld_rvalid pulses for exactly one cycle and the matching data output = mem_rdata.
  - A loader write never produces ld_rvalid.
  - The non-owning data output holds its last value.
- Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Address bits above MEM_AW+1 are ignored (wrap). Bits [1:0] are ignored.
- Reset values:
  - fetch_rvalid, ld_rvalid, fetch_inst, ld_rdata = 0.
  - FSM = LD_PRI, burst_cnt = 0, rd_owner = NONE.
  - Combinational outputs follow the inputs immediately after reset.
- Reset asserted mid-operation: any pending read return is dropped (no rvalid the next cycle). Grants are still computed combinationally during reset, but no state updates.
- Requesters hold req/addr/wdata stable until they see their gnt. A requester may drop req before gnt with no side effect.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- Enabled:
  - Adds output stall_cnt [15:0]: counts cycles with cpu_stall=1, saturates at 16'hFFFF, reset 0.
  - Adds output ld_wr_cnt [15:0]: counts granted loader writes, saturates, reset 0.
- Disabled: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Fetch only, addresses 0x0, 0x4, 0x8 on consecutive cycles -> fetch_gnt each cycle; mem_addr = 0, 1, 2; fetch_rvalid each following cycle with fetch_inst = mem[0..2].
- Loader writes 0xDEADBEEF to 0x10, then reads 0x10 -> mem_we=1 with mem_addr=4 first; next access ld_rvalid one cycle after the read grant with ld_rdata = 0xDEADBEEF; no ld_rvalid after the write.
- ld_req and fetch_req held high 12 cycles, MAX_LD_BURST=4 -> grant pattern L,L,L,L,F repeating; cpu_stall high on L cycles.
- Fetch address 0x400 (beyond depth) -> mem_addr = 0 (wrap).
- Fetch granted in cycle N, rst=1 in cycle N+1 -> no fetch_rvalid in N+1; all registered outputs 0; FSM LD_PRI.
- With IMEM_ARB_STATS_EN: 5 stalled cycles and 3 loader writes -> stall_cnt = 5, ld_wr_cnt = 3. Force the counter to 0xFFFF plus one more stall -> stays 0xFFFF.
